// File: rtl/cwe1262_lockable_bank.sv
// cwe1262_lockable_bank: DEPTH x WIDTH register bank behind one sticky lock,
// with a buffered write response and a saturating lock-violation counter.
module cwe1262_lockable_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [63:0] RESET_VAL = 64'd0,
  parameter int CNT_W = 8,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_err,
  input  logic             lock_req,
  output logic             locked,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] viol_count,
  output logic             viol_flag
);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic accept, wr_ok, rd_ok;
  assign wr_ready = !resp_valid || resp_ready;
  assign accept = wr_valid && wr_ready;
  assign wr_ok = {1'b0, wr_addr} < DEPTH_W;
  assign rd_ok = {1'b0, rd_addr} < DEPTH_W;
  assign locked = state == LOCKED;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == UNLOCKED && lock_req) ? LOCKED : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= UNLOCKED;
    else state <= state_nxt;
  // The lock check uses the pre-edge state, so a write paired with lock_req still lands.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RV;
    end else if (accept && !locked && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data <= RV;
    else rd_data <= rd_ok ? mem[rd_addr] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err <= locked || !wr_ok;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      viol_count <= '0;
      viol_flag <= 1'b0;
    end else if (accept && locked) begin
      viol_flag <= 1'b1;
      viol_count <= (viol_count == '1) ? viol_count : viol_count + 1'b1;
    end
endmodule
